// File: rtl/miner_spi_pkg.sv
// Shared constants and types for the SPI miner hub.
// Contents: command opcodes, job/sync constants, status byte bit positions,
// command-state enum and the FIFO entry width.
package miner_spi_pkg;

    localparam logic [7:0] OP_STATUS = 8'h01;
    localparam logic [7:0] OP_NONCE  = 8'h02;
    localparam logic [7:0] OP_JOB    = 8'h10;
    localparam logic [7:0] OP_CLEAR  = 8'h20;

    localparam int unsigned JOB_BYTES = 76;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    // Status byte layout: {overflow, any core busy, fifo count[5:0]}
    localparam int unsigned STATUS_OVF_BIT   = 7;
    localparam int unsigned STATUS_BUSY_BIT  = 6;
    localparam int unsigned STATUS_COUNT_MSB = 5;

    // FIFO entry: {core index byte, nonce}
    localparam int unsigned ENTRY_W = 40;

    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        STATUS,
        NONCE,
        JOB,
        DISCARD
    } cmd_state_e;

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous result FIFO.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write;
// pop_i read (data_o shows the head); flush_i empties the FIFO;
// full_o/empty_o/count_o report occupancy.
// A push while full is accepted only when a pop happens in the same cycle.
module nonce_fifo #(
    parameter int unsigned Width = 40,
    parameter int unsigned Depth = 8,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/spi_miner_hub.sv
// SPI slave and job/result hub for a multi-core SHA-256 miner.
// Ports: CLK100MHZ system clock; reset async active-low; sclk/mosi/cs SPI
// inputs (cs active-low, mode 0); miso SPI output; midstate/header/target
// committed job; job_start one-cycle commit pulse; core_busy/found_valid/
// found_nonce from cores; found_ack one-hot acknowledge to the winning core.
module spi_miner_hub
    import miner_spi_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    CLK100MHZ,
    input  logic                    reset,
    input  logic                    sclk,
    input  logic                    mosi,
    input  logic                    cs,
    output logic                    miso,
    output logic [255:0]            midstate,
    output logic [95:0]             header,
    output logic [255:0]            target,
    output logic                    job_start,
    input  logic [NUM_CORES-1:0]    core_busy,
    input  logic [NUM_CORES-1:0]    found_valid,
    input  logic [32*NUM_CORES-1:0] found_nonce,
    output logic [NUM_CORES-1:0]    found_ack
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    // ---------------- synchronisers and edge detection ----------------
    logic [2:0] sync_q [SYNC_STAGES];  // {cs, mosi, sclk}
    logic       sclk_s, mosi_s, cs_s;
    logic       sclk_prev_q, cs_prev_q;
    logic       sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;

    assign {cs_s, mosi_s, sclk_s} = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b100;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
        end else begin
            sync_q[0] <= {cs, mosi, sclk};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            sclk_rise_q <= sclk_s & ~sclk_prev_q;
            sclk_fall_q <= ~sclk_s & sclk_prev_q;
            cs_rise_q   <= cs_s & ~cs_prev_q;
            cs_fall_q   <= ~cs_s & cs_prev_q;
        end
    end

    // ---------------- result arbitration and FIFO ----------------
    logic [NUM_CORES-1:0] req, gnt_oh, found_ack_q;
    logic                 gnt_valid;
    logic [3:0]           gnt_idx;
    logic [31:0]          gnt_nonce;
    logic                 fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]   fifo_head;
    logic [CNT_W-1:0]     fifo_count;
    logic                 ovf_q;

    // A core stays valid during its ack cycle; mask it so it is not granted twice.
    assign req = found_valid & ~found_ack_q;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (req[i] && !gnt_valid) begin
                gnt_valid = 1'b1;
                gnt_idx   = 4'(i);
            end
        end
        gnt_oh    = gnt_valid ? (NUM_CORES'(1) << gnt_idx) : '0;
        gnt_nonce = found_nonce[32*gnt_idx +: 32];
    end

    nonce_fifo #(
        .Width (ENTRY_W),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK100MHZ),
        .rst_ni  (reset),
        .push_i  (gnt_valid),
        .data_i  ({4'h0, gnt_idx, gnt_nonce}),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            found_ack_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            found_ack_q <= gnt_oh;
            if (fifo_flush) ovf_q <= 1'b0;
            else if (gnt_valid && fifo_full && !fifo_pop) ovf_q <= 1'b1;
        end
    end

    assign found_ack = found_ack_q;

    // ---------------- command FSM ----------------
    cmd_state_e         state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [6:0]         byte_cnt_q, byte_cnt_d;
    logic [7:0]         rx_q, rx_d, rx_byte;
    logic [7:0]         tx_shift_q, tx_shift_d, tx_next_q, tx_next_d;
    logic               miso_q, miso_d;
    logic [ENTRY_W-1:0] snap_q, snap_d;
    logic [607:0]       shadow_q, shadow_d;
    logic               commit;
    logic [7:0]         status_byte;

    always_comb begin
        status_byte                     = '0;
        status_byte[STATUS_OVF_BIT]     = ovf_q;
        status_byte[STATUS_BUSY_BIT]    = |core_busy;
        status_byte[STATUS_COUNT_MSB:0] = 6'(fifo_count);
    end

    assign rx_byte = {rx_q[6:0], mosi_s};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rx_d       = rx_q;
        tx_shift_d = tx_shift_q;
        tx_next_d  = tx_next_q;
        miso_d     = miso_q;
        snap_d     = snap_q;
        shadow_d   = shadow_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        commit     = 1'b0;

        if (cs_fall_q) begin
            state_d    = OPCODE;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            miso_d     = SYNC_BYTE[7];
            tx_shift_d = {SYNC_BYTE[6:0], 1'b0};
        end else if (cs_rise_q) begin
            // Also aborts a partial byte: counters restart on the next cs fall.
            commit     = (state_q == JOB) && (byte_cnt_q == 7'(JOB_BYTES));
            state_d    = IDLE;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            miso_d     = 1'b0;
        end else if (state_q != IDLE) begin
            if (sclk_rise_q) begin
                rx_d      = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    tx_next_d = 8'h00;
                    case (state_q)
                        OPCODE: begin
                            byte_cnt_d = '0;
                            case (rx_byte)
                                OP_STATUS: begin
                                    state_d   = STATUS;
                                    tx_next_d = status_byte;
                                end
                                OP_NONCE: begin
                                    state_d = NONCE;
                                    if (!fifo_empty) begin
                                        fifo_pop = 1'b1;
                                        snap_d   = fifo_head;
                                    end else begin
                                        snap_d = '1;
                                    end
                                    tx_next_d = snap_d[39:32];
                                end
                                OP_JOB:   state_d = JOB;
                                OP_CLEAR: begin
                                    fifo_flush = 1'b1;
                                    state_d    = DISCARD;
                                end
                                default:  state_d = DISCARD;
                            endcase
                        end
                        STATUS: state_d = DISCARD;
                        NONCE: begin
                            byte_cnt_d = byte_cnt_q + 7'd1;
                            case (byte_cnt_q)
                                7'd0:    tx_next_d = snap_q[31:24];
                                7'd1:    tx_next_d = snap_q[23:16];
                                7'd2:    tx_next_d = snap_q[15:8];
                                7'd3:    tx_next_d = snap_q[7:0];
                                default: state_d   = DISCARD;
                            endcase
                        end
                        JOB: begin
                            if (byte_cnt_q < 7'(JOB_BYTES)) begin
                                shadow_d[8*byte_cnt_q +: 8] = rx_byte;
                            end
                            // Saturate so an over-long job never wraps back to 76.
                            if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 7'd1;
                        end
                        default: ;
                    endcase
                end
            end
            if (sclk_fall_q) begin
                // bit_cnt 0 here means a byte just finished: start the next one.
                if (bit_cnt_q == 3'd0) begin
                    miso_d     = tx_next_q[7];
                    tx_shift_d = {tx_next_q[6:0], 1'b0};
                end else begin
                    miso_d     = tx_shift_q[7];
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            rx_q       <= '0;
            tx_shift_q <= '0;
            tx_next_q  <= '0;
            miso_q     <= 1'b0;
            snap_q     <= '0;
            shadow_q   <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rx_q       <= rx_d;
            tx_shift_q <= tx_shift_d;
            tx_next_q  <= tx_next_d;
            miso_q     <= miso_d;
            snap_q     <= snap_d;
            shadow_q   <= shadow_d;
        end
    end

    assign miso = miso_q;

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            midstate  <= '0;
            header    <= '0;
            target    <= '0;
            job_start <= 1'b0;
        end else begin
            job_start <= commit;
            if (commit) begin
                midstate <= shadow_q[255:0];
                header   <= shadow_q[351:256];
                target   <= shadow_q[607:352];
            end
        end
    end

endmodule

// File: tb/tb_spi_miner_hub.sv
// Self-checking bench for spi_miner_hub: SPI master tasks, a MISO byte
// scoreboard and simple core models driving found_valid/found_nonce.
module tb_spi_miner_hub;
    import miner_spi_pkg::*;

    localparam int unsigned NUM_CORES   = 4;
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HALF        = 8;  // sclk half period in clocks

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    sclk, mosi, cs, miso;
    logic [255:0]            midstate, target;
    logic [95:0]             header;
    logic                    job_start;
    logic [NUM_CORES-1:0]    core_busy, found_valid, found_ack;
    logic [32*NUM_CORES-1:0] found_nonce;

    int n_checks = 0;
    int n_fail   = 0;
    int js_cnt   = 0;

    logic [7:0] exp_q [$];
    string      tag_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) if (job_start) js_cnt++;

    spi_miner_hub #(
        .NUM_CORES   (NUM_CORES),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK100MHZ   (clk),
        .reset       (rst_n),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs          (cs),
        .miso        (miso),
        .midstate    (midstate),
        .header      (header),
        .target      (target),
        .job_start   (job_start),
        .core_busy   (core_busy),
        .found_valid (found_valid),
        .found_nonce (found_nonce),
        .found_ack   (found_ack)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_begin();
        @(negedge clk);
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_end();
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Push the expected MISO byte, clock the byte, pop and compare.
    task automatic xfer_exp(input string tag, input logic [7:0] tx, input logic [7:0] exp);
        logic [7:0] rx;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        spi_xfer(tx, rx);
        check(tag_q.pop_front(), 256'(rx), 256'(exp_q.pop_front()));
    endtask

    task automatic read_status(input string tag, input logic [7:0] exp);
        spi_begin();
        xfer_exp({tag, "_sync"}, OP_STATUS, SYNC_BYTE);
        xfer_exp(tag, 8'h00, exp);
        spi_end();
    endtask

    task automatic read_nonce(input string tag, input logic [7:0] idx, input logic [31:0] nonce);
        spi_begin();
        xfer_exp({tag, "_sync"}, OP_NONCE, SYNC_BYTE);
        xfer_exp({tag, "_idx"}, 8'h00, idx);
        for (int b = 3; b >= 0; b--) xfer_exp({tag, "_nonce"}, 8'h00, nonce[8*b +: 8]);
        spi_end();
    endtask

    task automatic write_job(input logic [607:0] job, input int nbytes);
        spi_begin();
        xfer_exp("job_sync", OP_JOB, SYNC_BYTE);
        for (int k = 0; k < nbytes; k++) xfer_exp("job_data", job[8*k +: 8], 8'h00);
        spi_end();
    endtask

    // Single core raises found; wait (bounded) for its ack, then drop valid.
    task automatic push_nonce(input int core, input logic [31:0] nonce);
        logic got_ack = 1'b0;
        @(negedge clk);
        found_nonce[32*core +: 32] = nonce;
        found_valid[core] = 1'b1;
        for (int c = 0; c < 8 && !got_ack; c++) begin
            @(negedge clk);
            if (found_ack[core]) got_ack = 1'b1;
        end
        found_valid[core] = 1'b0;
        check("push_ack", 256'(got_ack), 256'(1));
        @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] ms, tg, ms2;
        logic [95:0]  hd;
        logic [607:0] job, job2;
        int           js_before;

        ms  = 256'h4a03aeb2_1f3c5d7e_8899aabb_ccddeeff_01234567_89abcdef_fedcba98_ddef7254;
        hd  = 96'h15274c646c51f957c4400418;
        tg  = 256'h00000000_00000000_00000000_00000000_00000000_0440c400_00000000_00000000;
        ms2 = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
        job  = {tg, hd, ms};
        job2 = {~tg, ~hd, ms2};

        rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs = 1'b1;
        core_busy = '0; found_valid = '0; found_nonce = '0;
        repeat (5) @(negedge clk);
        check("rst_miso", 256'(miso), 256'(0));
        check("rst_midstate", midstate, 256'(0));
        check("rst_ack", 256'(found_ack), 256'(0));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        read_status("status_reset", 8'h00);

        // Full job commit
        js_before = js_cnt;
        write_job(job, JOB_BYTES);
        check("job_midstate", midstate, ms);
        check("job_header", 256'(header), 256'(hd));
        check("job_target", target, tg);
        check("job_start_pulses", 256'(js_cnt - js_before), 256'(1));

        // Aborted job leaves outputs alone
        js_before = js_cnt;
        write_job(job2, 40);
        check("abort_midstate", midstate, ms);
        check("abort_target", target, tg);
        check("abort_no_start", 256'(js_cnt - js_before), 256'(0));

        // Cores 1 and 3 find in the same cycle: lower index wins first
        @(negedge clk);
        found_nonce[32 +: 32] = 32'h9c9a4fcb;
        found_nonce[96 +: 32] = 32'h12345678;
        found_valid = 4'b1010;
        @(negedge clk);
        check("arb_first", 256'(found_ack), 256'(4'b0010));
        found_valid[1] = 1'b0;
        @(negedge clk);
        check("arb_second", 256'(found_ack), 256'(4'b1000));
        found_valid[3] = 1'b0;
        @(negedge clk);
        check("arb_idle", 256'(found_ack), 256'(0));
        read_status("status_two", 8'h02);
        read_nonce("nonce_a", 8'h01, 32'h9c9a4fcb);
        read_nonce("nonce_b", 8'h03, 32'h12345678);
        read_status("status_drained", 8'h00);

        // Overflow: one more than the FIFO holds
        for (int i = 0; i <= FIFO_DEPTH; i++) push_nonce(0, 32'hA000_0000 + i);
        core_busy = 4'b0100;
        read_status("status_ovf", 8'hC0 | 8'(FIFO_DEPTH));
        core_busy = '0;
        read_nonce("nonce_ovf_head", 8'h00, 32'hA000_0000);
        read_status("status_after_pop", 8'h80 | 8'(FIFO_DEPTH - 1));
        spi_begin();
        xfer_exp("clear_sync", OP_CLEAR, SYNC_BYTE);
        xfer_exp("clear_tail", 8'h00, 8'h00);
        spi_end();
        read_status("status_cleared", 8'h00);

        read_nonce("nonce_empty", 8'hFF, 32'hFFFFFFFF);

        // Unknown opcode returns zeros
        spi_begin();
        xfer_exp("unk_sync", 8'h77, SYNC_BYTE);
        xfer_exp("unk_data", 8'h00, 8'h00);
        spi_end();

        // Reset in the middle of a job write
        spi_begin();
        xfer_exp("rst_job_sync", OP_JOB, SYNC_BYTE);
        xfer_exp("rst_job_data", 8'h5A, 8'h00);
        mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_miso", 256'(miso), 256'(0));
        check("midrst_midstate", midstate, 256'(0));
        check("midrst_header", 256'(header), 256'(0));
        check("midrst_target", target, 256'(0));
        check("midrst_job_start", 256'(job_start), 256'(0));
        check("midrst_ack", 256'(found_ack), 256'(0));
        sclk = 1'b0;
        cs = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        read_status("status_post_reset", 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
